// File: rtl/imsharp_window_gen_if.sv
// Pixel-stream and 5x5 window bundle for imsharp_window_gen.
// The testbench uses this bundle to drive and observe the flat ports of the window generator.
interface imsharp_window_gen_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] win_pix [25];
  logic       win_valid;
  logic       frame_done;

  modport master (output pix_in, pix_valid, sof,
                  input  win_pix, win_valid, frame_done);
  modport slave  (input  pix_in, pix_valid, sof,
                  output win_pix, win_valid, frame_done);
endinterface

// File: rtl/imsharp_window_gen.sv
// 5x5 raster window generator: four line buffers feed a shifting register window;
// in-image windows are copied to a held output set that the sharpening datapath consumes.
module imsharp_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] input_pixel_1,  output logic [7:0] input_pixel_2,
  output logic [7:0] input_pixel_3,  output logic [7:0] input_pixel_4,
  output logic [7:0] input_pixel_5,  output logic [7:0] input_pixel_6,
  output logic [7:0] input_pixel_7,  output logic [7:0] input_pixel_8,
  output logic [7:0] input_pixel_9,  output logic [7:0] input_pixel_10,
  output logic [7:0] input_pixel_11, output logic [7:0] input_pixel_12,
  output logic [7:0] input_pixel_13, output logic [7:0] input_pixel_14,
  output logic [7:0] input_pixel_15, output logic [7:0] input_pixel_16,
  output logic [7:0] input_pixel_17, output logic [7:0] input_pixel_18,
  output logic [7:0] input_pixel_19, output logic [7:0] input_pixel_20,
  output logic [7:0] input_pixel_21, output logic [7:0] input_pixel_22,
  output logic [7:0] input_pixel_23, output logic [7:0] input_pixel_24,
  output logic [7:0] input_pixel_25,
  output logic       win_valid,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, ec;
  logic [RW-1:0] row, er;
  logic [7:0]    lb   [4][IMG_WIDTH];
  logic [7:0]    win  [5][5];
  logic [7:0]    nxt  [5][5];
  logic [7:0]    held [5][5];
  logic          last_col, last_row, in_image;

  // sof overrides the counters so the tagged pixel is always (0,0)
  always_comb begin
    ec       = sof ? '0 : col;
    er       = sof ? '0 : row;
    last_col = (ec == COL_LAST);
    last_row = (er == ROW_LAST);
    in_image = (er >= RW'(4)) && (ec >= CW'(4));
    for (int unsigned i = 0; i < 5; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        nxt[i][j] = win[i][j+1];
      end
    end
    nxt[0][4] = lb[3][ec];
    nxt[1][4] = lb[2][ec];
    nxt[2][4] = lb[1][ec];
    nxt[3][4] = lb[0][ec];
    nxt[4][4] = pix_in;
  end

  // lb[k][c] holds row r-1-k at column c; stale rows are masked by the row>=4 gate
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb[0][ec] <= pix_in;
      lb[1][ec] <= lb[0][ec];
      lb[2][ec] <= lb[1][ec];
      lb[3][ec] <= lb[2][ec];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win        <= '{default: '0};
      held       <= '{default: '0};
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        win <= nxt;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : er + 1'b1;
        end else begin
          col <= ec + 1'b1;
          row <= er;
        end
        win_valid  <= in_image;
        frame_done <= last_col && last_row;
        if (in_image) held <= nxt;
      end
    end
  end

  assign input_pixel_1  = held[0][0];
  assign input_pixel_2  = held[0][1];
  assign input_pixel_3  = held[0][2];
  assign input_pixel_4  = held[0][3];
  assign input_pixel_5  = held[0][4];
  assign input_pixel_6  = held[1][0];
  assign input_pixel_7  = held[1][1];
  assign input_pixel_8  = held[1][2];
  assign input_pixel_9  = held[1][3];
  assign input_pixel_10 = held[1][4];
  assign input_pixel_11 = held[2][0];
  assign input_pixel_12 = held[2][1];
  assign input_pixel_13 = held[2][2];
  assign input_pixel_14 = held[2][3];
  assign input_pixel_15 = held[2][4];
  assign input_pixel_16 = held[3][0];
  assign input_pixel_17 = held[3][1];
  assign input_pixel_18 = held[3][2];
  assign input_pixel_19 = held[3][3];
  assign input_pixel_20 = held[3][4];
  assign input_pixel_21 = held[4][0];
  assign input_pixel_22 = held[4][1];
  assign input_pixel_23 = held[4][2];
  assign input_pixel_24 = held[4][3];
  assign input_pixel_25 = held[4][4];
endmodule

// File: tb/tb_imsharp_window_gen.sv
// Scoreboard bench for imsharp_window_gen on an 8x8 image: a frame-array model
// queues expected windows per accepted pixel and a monitor checks every output cycle.
module tb_imsharp_window_gen;
  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  imsharp_window_gen_if bus ();

  imsharp_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .Reset(Reset),
    .pix_in(bus.pix_in), .pix_valid(bus.pix_valid), .sof(bus.sof),
    .input_pixel_1(bus.win_pix[0]),   .input_pixel_2(bus.win_pix[1]),
    .input_pixel_3(bus.win_pix[2]),   .input_pixel_4(bus.win_pix[3]),
    .input_pixel_5(bus.win_pix[4]),   .input_pixel_6(bus.win_pix[5]),
    .input_pixel_7(bus.win_pix[6]),   .input_pixel_8(bus.win_pix[7]),
    .input_pixel_9(bus.win_pix[8]),   .input_pixel_10(bus.win_pix[9]),
    .input_pixel_11(bus.win_pix[10]), .input_pixel_12(bus.win_pix[11]),
    .input_pixel_13(bus.win_pix[12]), .input_pixel_14(bus.win_pix[13]),
    .input_pixel_15(bus.win_pix[14]), .input_pixel_16(bus.win_pix[15]),
    .input_pixel_17(bus.win_pix[16]), .input_pixel_18(bus.win_pix[17]),
    .input_pixel_19(bus.win_pix[18]), .input_pixel_20(bus.win_pix[19]),
    .input_pixel_21(bus.win_pix[20]), .input_pixel_22(bus.win_pix[21]),
    .input_pixel_23(bus.win_pix[22]), .input_pixel_24(bus.win_pix[23]),
    .input_pixel_25(bus.win_pix[24]),
    .win_valid(bus.win_valid), .frame_done(bus.frame_done)
  );

  int errors = 0;
  int checks = 0;
  int nwin   = 0;
  int nfd    = 0;
  bit alt_mode = 1'b0;

  logic [7:0]   img [H][W];
  int           mr = 0, mc = 0;
  logic [200:0] expq [$];
  logic [199:0] last_win = '0;
  logic         prev_valid = 1'b0;

  function automatic logic [199:0] dut_window();
    logic [199:0] v;
    for (int k = 0; k < 25; k++) v[k*8 +: 8] = bus.win_pix[k];
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: store the pixel at its raster position and, for an in-image
  // position, queue the 5x5 neighbourhood ending at it.
  task automatic send(input logic [7:0] p, input logic s);
    logic [200:0] e;
    @(posedge clk); #1;
    bus.pix_in = p; bus.sof = s; bus.pix_valid = 1'b1;
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    if (mr >= 4 && mc >= 4) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          e[(5*i+j)*8 +: 8] = img[mr-4+i][mc-4+j];
      e[200] = (mr == H-1 && mc == W-1);
      expq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0; mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b0; bus.sof = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [199:0] cur;
    logic [200:0] e;
    if (Reset) begin
      last_win   = '0;
      prev_valid = 1'b0;
    end else begin
      cur = dut_window();
      checks++;
      if (bus.win_valid) begin
        nwin++;
        if (bus.frame_done) nfd++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got %h with no window expected", cur);
        end else begin
          e = expq.pop_front();
          if (cur !== e[199:0] || bus.frame_done !== e[200]) begin
            errors++;
            $display("FAIL window: got %h fd=%b expected %h fd=%b", cur, bus.frame_done, e[199:0], e[200]);
          end
          last_win = e[199:0];
        end
        if (alt_mode) begin
          checks++;
          if (prev_valid) begin
            errors++;
            $display("FAIL back_to_back_valid: got 1 expected 0");
          end
        end
      end else if (bus.frame_done !== 1'b0 || cur !== last_win) begin
        errors++;
        $display("FAIL hold: got %h fd=%b expected %h fd=0", cur, bus.frame_done, last_win);
      end
      prev_valid = bus.win_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_win_valid", int'(bus.win_valid), 0);
    check("reset_frame_done", int'(bus.frame_done), 0);
    check("reset_window_zero", int'(dut_window() == '0), 1);
    Reset = 1'b0;

    // Continuous ramp frame
    nwin = 0; nfd = 0;
    for (int k = 0; k < 64; k++) send(8'(k), k == 0);
    idle(3);
    check("ramp_windows", nwin, 16);
    check("ramp_frame_done", nfd, 1);
    check("ramp_last_ip1", int'(last_win[7:0]), 27);
    check("ramp_last_ip13", int'(last_win[12*8 +: 8]), 45);
    check("ramp_last_ip25", int'(last_win[24*8 +: 8]), 63);

    // Same frame with pix_valid low every other cycle
    nwin = 0; nfd = 0; alt_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin send(8'(k), k == 0); idle(1); end
    idle(2);
    alt_mode = 1'b0;
    check("gap_windows", nwin, 16);
    check("gap_frame_done", nfd, 1);

    // sof reasserted on pixel 40 aborts the partial frame
    nwin = 0; nfd = 0;
    for (int k = 0; k < 40; k++) send(8'($urandom), k == 0);
    for (int k = 0; k < 64; k++) send(8'($urandom), k == 0);
    idle(3);
    check("abort_windows", nwin, 20);
    check("abort_frame_done", nfd, 1);

    // Reset mid-frame after pixel 45, then a frame without sof
    nwin = 0; nfd = 0;
    for (int k = 0; k < 46; k++) send(8'(k), k == 0);
    idle(3);
    check("prereset_windows", nwin, 6);
    check("prereset_queue_empty", expq.size(), 0);
    @(posedge clk); #2;
    Reset = 1'b1;
    #1;
    check("midreset_win_valid", int'(bus.win_valid), 0);
    check("midreset_frame_done", int'(bus.frame_done), 0);
    check("midreset_window_zero", int'(dut_window() == '0), 1);
    expq.delete();
    mr = 0; mc = 0;
    @(posedge clk); #1;
    Reset = 1'b0;
    nwin = 0; nfd = 0;
    for (int k = 0; k < 64; k++) send(8'($urandom), 1'b0);
    idle(3);
    check("postreset_windows", nwin, 16);
    check("postreset_frame_done", nfd, 1);

    // Back-to-back frames, then one frame with random gaps
    nwin = 0; nfd = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 64; k++) send(8'($urandom), k == 0);
    for (int k = 0; k < 64; k++) begin
      send(8'($urandom), k == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("b2b_windows", nwin, 48);
    check("b2b_frame_done", nfd, 3);
    check("final_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
